// File: rtl/washer_view_scan.sv
// Registered, frame-latched washer front-panel view driving a scanned seven-segment bus.
// Optional blinking of pause/error/finish indicators is compiled in with WASHER_VIEW_BLINK_EN.
module washer_view_scan #(
    parameter int DIGITS       = 3,
    parameter int LEDS         = 8,
    parameter int CODE_W       = 6,
    parameter int SCAN_DIV     = 1000,
    parameter int BLINK_FRAMES = 64
) (
    input  logic                       cp,
    input  logic                       rst_n,
    input  logic [2:0]                 state,
    input  logic [DIGITS*CODE_W-1:0]   digit_code,
    input  logic [LEDS-1:0]            led_data,
    input  logic                       power_in,
    input  logic                       set_in,
    output logic [7:0]                 seg,
    output logic [DIGITS-1:0]          dig_sel,
    output logic [LEDS-1:0]            led,
    output logic                       power_led,
    output logic                       set_led
);
    localparam int SCAN_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IDX_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_DIV - 1);
    localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(DIGITS - 1);
    localparam logic [IDX_W-1:0]  IDX_MID   = IDX_W'(DIGITS / 2);

    localparam logic [2:0] ST_SHUTDOWN = 3'd0;
    localparam logic [2:0] ST_BEGIN    = 3'd1;
    localparam logic [2:0] ST_ERROR    = 3'd4;
    localparam logic [2:0] ST_PAUSE    = 3'd5;
    localparam logic [2:0] ST_FINISH   = 3'd6;

    localparam logic [CODE_W-1:0] CODE_BLANK = CODE_W'(55);
    localparam logic [CODE_W-1:0] CODE_ALL   = CODE_W'(56);
    localparam logic [CODE_W-1:0] CODE_P     = CODE_W'(57);
    localparam logic [CODE_W-1:0] CODE_E     = CODE_W'(58);

    function automatic logic [6:0] seg_decode(input logic [CODE_W-1:0] code);
        logic [6:0] glyph;
        case (code)
            CODE_W'(0): glyph = 7'h3F;
            CODE_W'(1): glyph = 7'h06;
            CODE_W'(2): glyph = 7'h5B;
            CODE_W'(3): glyph = 7'h4F;
            CODE_W'(4): glyph = 7'h66;
            CODE_W'(5): glyph = 7'h6D;
            CODE_W'(6): glyph = 7'h7D;
            CODE_W'(7): glyph = 7'h07;
            CODE_W'(8): glyph = 7'h7F;
            CODE_W'(9): glyph = 7'h6F;
            CODE_ALL:   glyph = 7'h7F;
            CODE_P:     glyph = 7'h73;
            CODE_E:     glyph = 7'h79;
            default:    glyph = 7'h00;
        endcase
        return glyph;
    endfunction

    logic [SCAN_W-1:0]        scan_cnt_r;
    logic [IDX_W-1:0]         dig_idx_r;
    logic [2:0]               sh_state_r;
    logic [DIGITS*CODE_W-1:0] sh_code_r;
    logic [LEDS-1:0]          sh_led_r;
    logic                     sh_power_r;
    logic                     sh_set_r;
    logic                     scan_last_s;
    logic                     wrap_s;
    logic                     blink_phase_s;
    logic                     is_mid_s;
    logic [CODE_W-1:0]        cur_code_s;
    logic [CODE_W-1:0]        eff_code_s;
    logic                     blank_s;
    logic [7:0]               seg_next_s;
    logic [LEDS-1:0]          led_next_s;
    logic [DIGITS-1:0]        dig_sel_next_s;

    assign scan_last_s = (scan_cnt_r == SCAN_LAST);
    assign wrap_s      = scan_last_s && (dig_idx_r == IDX_LAST);

    // Slot timer and digit index.
    always_ff @(posedge cp or negedge rst_n) begin
        if (!rst_n) begin
            scan_cnt_r <= '0;
            dig_idx_r  <= '0;
        end else if (scan_last_s) begin
            scan_cnt_r <= '0;
            dig_idx_r  <= (dig_idx_r == IDX_LAST) ? '0 : dig_idx_r + IDX_W'(1);
        end else begin
            scan_cnt_r <= scan_cnt_r + SCAN_W'(1);
        end
    end

    // Frame shadows: loaded only on the wrap edge so one frame never mixes two input sets.
    always_ff @(posedge cp or negedge rst_n) begin
        if (!rst_n) begin
            sh_state_r <= ST_SHUTDOWN;
            sh_code_r  <= '0;
            sh_led_r   <= '1;
            sh_power_r <= 1'b0;
            sh_set_r   <= 1'b0;
        end else if (wrap_s) begin
            sh_state_r <= state;
            sh_code_r  <= digit_code;
            sh_led_r   <= led_data;
            sh_power_r <= power_in;
            sh_set_r   <= set_in;
        end
    end

`ifdef WASHER_VIEW_BLINK_EN
    localparam int BLINK_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_FRAMES - 1);
    logic [BLINK_W-1:0] blink_cnt_r;
    logic               blink_phase_r;

    // Blink phase flips together with the shadow load, so a frame sees one phase only.
    always_ff @(posedge cp or negedge rst_n) begin
        if (!rst_n) begin
            blink_cnt_r   <= '0;
            blink_phase_r <= 1'b0;
        end else if (wrap_s) begin
            if (blink_cnt_r == BLINK_LAST) begin
                blink_cnt_r   <= '0;
                blink_phase_r <= ~blink_phase_r;
            end else begin
                blink_cnt_r <= blink_cnt_r + BLINK_W'(1);
            end
        end
    end
    assign blink_phase_s = blink_phase_r;
`else
    assign blink_phase_s = 1'b0;
`endif

    // Per-digit code override, blink gating and LED override from the shadow state.
    always_comb begin
        is_mid_s   = (dig_idx_r == IDX_MID);
        cur_code_s = sh_code_r[int'(dig_idx_r) * CODE_W +: CODE_W];
        case (sh_state_r)
            ST_SHUTDOWN:         eff_code_s = CODE_BLANK;
            ST_BEGIN, ST_FINISH: eff_code_s = CODE_ALL;
            ST_ERROR:            eff_code_s = CODE_E;
            ST_PAUSE:            eff_code_s = is_mid_s ? CODE_P : cur_code_s;
            default:             eff_code_s = cur_code_s;
        endcase
        blank_s = blink_phase_s &&
                  ((sh_state_r == ST_ERROR) || (sh_state_r == ST_FINISH) ||
                   ((sh_state_r == ST_PAUSE) && is_mid_s));
        if (blank_s) begin
            seg_next_s = 8'h00;
        end else begin
            seg_next_s = {1'b0, seg_decode(eff_code_s)};
        end
        case (sh_state_r)
            ST_SHUTDOWN: led_next_s = '1;
            ST_BEGIN:    led_next_s = '0;
            ST_FINISH:   led_next_s = '1;
            ST_PAUSE:    led_next_s = blink_phase_s ? '1 : sh_led_r;
            default:     led_next_s = sh_led_r;
        endcase
        dig_sel_next_s = ~(DIGITS'(1) << dig_idx_r);
    end

    // Output registers: one cycle behind the digit index, all outputs on the same edge.
    always_ff @(posedge cp or negedge rst_n) begin
        if (!rst_n) begin
            seg       <= 8'h00;
            dig_sel   <= '1;
            led       <= '1;
            power_led <= 1'b0;
            set_led   <= 1'b0;
        end else begin
            seg       <= seg_next_s;
            dig_sel   <= dig_sel_next_s;
            led       <= led_next_s;
            power_led <= sh_power_r;
            set_led   <= sh_set_r;
        end
    end
endmodule

// File: tb/tb_washer_view_scan.sv
// Directed bench for washer_view_scan: a frame-position reference model pushes the expected
// outputs for each edge into a queue, which is popped and compared just after that edge.
module tb_washer_view_scan;
    localparam int D     = 3;
    localparam int L     = 8;
    localparam int CW    = 6;
    localparam int S     = 4;
    localparam int BF    = 2;
    localparam int FRAME = D * S;

    logic          cp = 1'b0;
    logic          rst_n = 1'b0;
    logic [2:0]    state = 3'd0;
    logic [D*CW-1:0] digit_code = '0;
    logic [L-1:0]  led_data = '1;
    logic          power_in = 1'b0;
    logic          set_in = 1'b0;
    logic [7:0]    seg;
    logic [D-1:0]  dig_sel;
    logic [L-1:0]  led;
    logic          power_led;
    logic          set_led;

    washer_view_scan #(
        .DIGITS(D), .LEDS(L), .CODE_W(CW), .SCAN_DIV(S), .BLINK_FRAMES(BF)
    ) dut (
        .cp(cp), .rst_n(rst_n), .state(state), .digit_code(digit_code),
        .led_data(led_data), .power_in(power_in), .set_in(set_in),
        .seg(seg), .dig_sel(dig_sel), .led(led),
        .power_led(power_led), .set_led(set_led)
    );

    always #5 cp = ~cp;

    typedef struct packed {
        logic [7:0]   seg;
        logic [D-1:0] dig_sel;
        logic [L-1:0] led;
        logic         pw;
        logic         st;
    } obs_t;

    obs_t exp_q[$];
    int   tests = 0;
    int   fails = 0;

    // Reference model: edges since reset, completed frames, and the inputs latched for this frame.
    int            pos;
    int            wraps;
    logic [2:0]    m_state;
    logic [D*CW-1:0] m_code;
    logic [L-1:0]  m_led;
    logic          m_pw;
    logic          m_st;

    function automatic logic [7:0] glyph(input int code);
        case (code)
            0: return 8'h3F;  1: return 8'h06;  2: return 8'h5B;  3: return 8'h4F;
            4: return 8'h66;  5: return 8'h6D;  6: return 8'h7D;  7: return 8'h07;
            8: return 8'h7F;  9: return 8'h6F; 56: return 8'h7F; 57: return 8'h73;
            58: return 8'h79;
            default: return 8'h00;
        endcase
    endfunction

    function automatic obs_t model_expect();
        obs_t e;
        int   d;
        int   c;
        bit   ph;
        bit   mid;
        d   = (pos / S) % D;
        mid = (d == D / 2);
`ifdef WASHER_VIEW_BLINK_EN
        ph = ((wraps / BF) % 2) == 1;
`else
        ph = 1'b0;
`endif
        c = int'(m_code[d*CW +: CW]);
        case (m_state)
            3'd0: c = 55;
            3'd1, 3'd6: c = 56;
            3'd4: c = 58;
            3'd5: if (mid) c = 57;
            default: ;
        endcase
        if (ph && (m_state == 3'd4 || m_state == 3'd6 || (m_state == 3'd5 && mid)))
            e.seg = 8'h00;
        else
            e.seg = glyph(c);
        e.dig_sel = ~(D'(1) << d);
        case (m_state)
            3'd0, 3'd6: e.led = 8'hFF;
            3'd1: e.led = 8'h00;
            3'd5: e.led = ph ? 8'hFF : m_led;
            default: e.led = m_led;
        endcase
        e.pw = m_pw;
        e.st = m_st;
        return e;
    endfunction

    task automatic reset_model();
        pos = 0; wraps = 0; m_state = 3'd0; m_code = '0; m_led = 8'hFF; m_pw = 1'b0; m_st = 1'b0;
    endtask

    task automatic check_out(input obs_t e, input string tag);
        tests++;
        assert (seg === e.seg) else begin
            fails++; $error("FAIL %s seg pos=%0d got %h expected %h", tag, pos, seg, e.seg);
        end
        tests++;
        assert (dig_sel === e.dig_sel) else begin
            fails++; $error("FAIL %s dig_sel pos=%0d got %b expected %b", tag, pos, dig_sel, e.dig_sel);
        end
        tests++;
        assert (led === e.led) else begin
            fails++; $error("FAIL %s led pos=%0d got %h expected %h", tag, pos, led, e.led);
        end
        tests++;
        assert ({power_led, set_led} === {e.pw, e.st}) else begin
            fails++; $error("FAIL %s pwr/set pos=%0d got %b%b expected %b%b", tag, pos,
                            power_led, set_led, e.pw, e.st);
        end
    endtask

    task automatic expect_reset(input string tag);
        obs_t r;
        r = '{seg: 8'h00, dig_sel: '1, led: 8'hFF, pw: 1'b0, st: 1'b0};
        exp_q.push_back(r);
        check_out(exp_q.pop_front(), tag);
    endtask

    // One clock edge: predict, latch model shadows on the wrap edge, then compare after the edge.
    task automatic tick(input string tag);
        exp_q.push_back(model_expect());
        if (pos % FRAME == FRAME - 1) begin
            m_state = state; m_code = digit_code; m_led = led_data;
            m_pw = power_in; m_st = set_in; wraps++;
        end
        pos++;
        @(posedge cp);
        #1;
        check_out(exp_q.pop_front(), tag);
    endtask

    task automatic run(input int n, input string tag);
        for (int i = 0; i < n; i++) tick(tag);
    endtask

    initial begin
        reset_model();
        state = 3'd3; digit_code = {6'd2, 6'd1, 6'd0}; led_data = 8'hA5;
        power_in = 1'b1; set_in = 1'b0;
        repeat (2) @(posedge cp);
        #1;
        expect_reset("reset");
        @(negedge cp);
        rst_n = 1'b1;
        run(3 * FRAME, "run");

        state = 3'd1;
        run(2 * FRAME, "begin");
        state = 3'd0;
        run(2 * FRAME, "shutdown");

        state = 3'd5; power_in = 1'b0; set_in = 1'b1; led_data = 8'h3C;
        run(9 * FRAME, "pause");
        state = 3'd4;
        run(5 * FRAME, "error");
        state = 3'd6;
        run(5 * FRAME, "finish");

        state = 3'd3; digit_code = {6'd9, 6'd63, 6'd7};
        run(2 * FRAME, "code63");
        state = 3'd7; digit_code = {6'd8, 6'd4, 6'd5};
        run(2 * FRAME, "state7");

        // Change codes in the middle of slot 1; the model keeps the old frame until the wrap.
        while (pos % FRAME != S + 1) tick("align");
        digit_code = {6'd3, 6'd6, 6'd9}; led_data = 8'h81;
        run(2 * FRAME, "midframe");

        // Asynchronous reset in the middle of slot 2, checked before any clock edge.
        while (pos % FRAME != 2 * S + 1) tick("align2");
        #3;
        rst_n = 1'b0;
        #1;
        expect_reset("async_rst");
        reset_model();
        repeat (2) begin
            @(posedge cp);
            #1;
            expect_reset("rst_hold");
        end
        @(negedge cp);
        rst_n = 1'b1;
        state = 3'd3; digit_code = {6'd2, 6'd5, 6'd1};
        run(3 * FRAME, "after_rst");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/washer_view_scan.md
# washer_view_scan

Parametrised, registered successor to the washer front-panel view logic. It applies the same state-driven display and LED overrides. It drives a time-multiplexed N-digit seven-segment bus with its own segment decoder, and latches a coherent frame at each scan wrap. In pause, error and finish states it blinks indicators. It sits between the washer controller (state, status LEDs, digit codes) and the board pins.

## Interface
Parameters:
- DIGITS, 3, number of scanned digits (≥2); digit 0 = leftmost, middle = DIGITS/2.
- LEDS, 8, number of status LEDs.
- CODE_W, 6, width of one digit code.
- SCAN_DIV, 1000, clock cycles per digit slot (≥2).
- BLINK_FRAMES, 64, scan frames per blink half-period (≥1).

Ports:
- cp  in  1  system clock; all logic on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- state  in  3  washer state: 0 shutdown, 1 begin, 2 set, 3 run, 4 error, 5 pause, 6 finish, 7 treated as run.
- digit_code  in  DIGITS*CODE_W  per-digit code; digit i at bits [i*CODE_W +: CODE_W].
- led_data  in  LEDS  status LEDs, active-low (1 = off).
- power_in, set_in  in  1 each  passed to power_led and set_led.
- seg  out  8  {dp,g,f,e,d,c,b,a}, active-high; dp always 0.
- dig_sel  out  DIGITS  one-hot active-low digit enable.
- led  out  LEDS  active-low status LEDs.
- power_led, set_led  out  1  registered copies of the frame-latched inputs.

## Operation
- Frame latch: state, digit_code, led_data, power_in and set_in load into shadow registers when the digit index wraps DIGITS-1→0. All outputs derive from the shadows only, so there is no tearing within a frame.
- Effective codes per digit, from the shadow state:
  - shutdown: 55.
  - begin and finish: 56.
  - error: 58.
  - pause: middle digit 57, others from digit_code.
  - otherwise: digit_code.
- Decoder:
  - 0–9: standard glyphs (0 = 0x3F, 1 = 0x06, … 8 = 0x7F, 9 = 0x6F).
  - 55: blank (0x00). 56: all segments (0x7F). 57: 'P' (0x73). 58: 'E' (0x79).
  - Any other code: blank.
- LEDs: shutdown → all 1; begin → all 0 (lamp test); finish → all 1; other states → led_data shadow.
- Blink (when compiled in), driven by blink_phase:
  - When blink_phase = 1: pause forces led to all 1 and blanks the middle digit; error and finish blank all digits.
  - When blink_phase = 0: normal display.
  - Other states never blink.
- power_led and set_led are never overridden.

## Timing
- scan_cnt counts 0..SCAN_DIV-1. At the terminal count it wraps to 0 and the digit index advances, wrapping at DIGITS-1.
- blink_cnt counts frame wraps 0..BLINK_FRAMES-1. At its terminal count blink_phase toggles.
- Digit slot n is active for exactly SCAN_DIV cycles. seg and dig_sel update on the same edge, with one cycle of register latency from the index change.
- A new input is visible at the outputs at the first digit-0 slot after the next wrap. Worst-case latency is DIGITS*SCAN_DIV+1 cycles.
- Frame-wrap and blink-toggle edge coincide: the shadow load and the phase toggle both take effect on that edge.
- Reset (async assert, any point mid-scan), values held until the first rising edge after deassertion:
  - seg = 0, dig_sel = all 1, led = all 1, power_led = set_led = 0.
  - All counters and the digit index = 0, blink_phase = 0.
  - Shadow state = shutdown.
- Deassertion is sampled synchronously: digit 0 is driven from the first edge after rst_n rises.

## Configuration
- WASHER_VIEW_BLINK_EN defined: blink_cnt, blink_phase and the blink gating are present as described.
- Not defined: blink_phase is constant 0 and the blink counter is removed. Pause shows steady 57 with led_data LEDs; error and finish show steady codes. All other behaviour and timing are unchanged.

## Test plan
Bench settings: DIGITS=3, SCAN_DIV=4, BLINK_FRAMES=2, macro defined.
- Reset then state=3, digit_code={2,1,0}, led_data=0xA5:
  - dig_sel cycles 110→101→011, each held 4 cycles.
  - seg 0x3F, 0x06, 0x5B on digits 0, 1, 2.
  - led = 0xA5 after the first wrap.
- state=1: all digits 0x7F, led = 0x00. state=0: seg 0x00, led = 0xFF.
- state=5 held for 8 frames: middle digit alternates 0x73 / blank every 2 frames; led alternates led_data / 0xFF in phase.
- state=4: all digits 0x79 blinking with a 2-frame half-period; digit_code=63 in run state gives blank.
- Change digit_code mid-frame (during slot 1): outputs unchanged until the next digit-0 slot; no mixed frame is observed.
- Assert rst_n=0 mid-slot 2: outputs go to reset values with no clock edge. After release, digit 0 is driven on the next edge, with scan_cnt restarting from 0.
